// File: rtl/ltssm_pkg.sv
// ltssm_pkg: shared LTSSM types and default timing constants.
// Provides the receiver-detection sequencer state enum (rxdet_sm_e), the
// default timeout / retry-wait cycle counts, and a helper that sizes the
// sequencer counters from the larger of the two cycle parameters.
package ltssm_pkg;

    typedef enum logic [2:0] {
        RXDET_IDLE,
        RXDET_REQ,
        RXDET_WAIT,
        RXDET_EVAL,
        RXDET_RETRY,
        RXDET_REPORT,
        RXDET_HOLD
    } rxdet_sm_e;

    localparam int RXDET_TIMEOUT_DEF    = 32;
    localparam int RXDET_RETRY_WAIT_DEF = 64;

    function automatic int rxdet_cnt_width(input int a, input int b);
        return $clog2(a > b ? a : b) + 1;
    endfunction

endpackage

// File: rtl/rxdet_counter.sv
// rxdet_counter: synchronous clear/enable up-counter with terminal-count flag.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset
//   clr_i  - synchronous clear to zero
//   en_i   - count enable
//   tc_o   - high while the count equals LIMIT-1 (decoded from the register)
// The count saturates at all-ones and never wraps.
module rxdet_counter #(
    parameter int WIDTH = 7,
    parameter int LIMIT = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i)
            r_cnt <= '0;
        else if (en_i && r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
    end

    assign tc_o = r_cnt == TC_VAL;

endmodule

// File: rtl/rx_detect_seq.sv
// rx_detect_seq: receiver-detection sequencer for the LTSSM Detect substate.
// Starts on Detect.Active, issues a one-cycle PHY receiver-detect request,
// collects the per-lane presence vector (or times out), optionally retries a
// partial result once, and reports a single lane-detect pulse plus the final
// detected-lane mask.
// Ports:
//   clk_i               - clock, rising edge
//   rst_i               - synchronous active-high reset
//   detect_active_i     - Detect.Active from the Detect controller
//   phy_rxdet_req_o     - one-cycle receiver-detect request to the PHY
//   phy_rxdet_done_i    - PHY detection complete, present vector valid
//   phy_rxdet_present_i - per-lane receiver present
//   lane_detect_o       - one-cycle pulse: at least one receiver confirmed
//   lanes_detected_o    - final detected-lane mask
//   busy_o              - sequence in progress
// Build option: define RX_DETECT_RETRY_EN to retry a partial first-attempt
// result after RETRY_WAIT_CYCLES; otherwise any nonzero first mask reports.
module rx_detect_seq
    import ltssm_pkg::*;
#(
    parameter int NUM_LANES         = 4,
    parameter int TIMEOUT_CYCLES    = RXDET_TIMEOUT_DEF,
    parameter int RETRY_WAIT_CYCLES = RXDET_RETRY_WAIT_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 detect_active_i,
    output logic                 phy_rxdet_req_o,
    input  logic                 phy_rxdet_done_i,
    input  logic [NUM_LANES-1:0] phy_rxdet_present_i,
    output logic                 lane_detect_o,
    output logic [NUM_LANES-1:0] lanes_detected_o,
    output logic                 busy_o
);

    localparam int CW = rxdet_cnt_width(TIMEOUT_CYCLES, RETRY_WAIT_CYCLES);

    rxdet_sm_e            r_state;
    rxdet_sm_e            w_next;
    rxdet_sm_e            w_eval_next;
    logic [NUM_LANES-1:0] r_mask;
    logic                 w_abort;
    logic                 w_to_tc;

    assign w_abort = !detect_active_i && r_state != RXDET_IDLE && r_state != RXDET_HOLD;

    rxdet_counter #(
        .WIDTH (CW),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (r_state != RXDET_WAIT),
        .en_i  (r_state == RXDET_WAIT),
        .tc_o  (w_to_tc)
    );

`ifdef RX_DETECT_RETRY_EN
    logic w_rt_tc;
    logic r_tried;
    logic r_second;

    rxdet_counter #(
        .WIDTH (CW),
        .LIMIT (RETRY_WAIT_CYCLES)
    ) u_retry_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (r_state != RXDET_RETRY),
        .en_i  (r_state == RXDET_RETRY),
        .tc_o  (w_rt_tc)
    );

    // r_tried marks that one request has already gone out; r_second latches
    // it on the next request so EVAL knows the current mask is final.
    always_ff @(posedge clk_i) begin
        if (rst_i || r_state == RXDET_IDLE) begin
            r_tried  <= 1'b0;
            r_second <= 1'b0;
        end else if (r_state == RXDET_REQ) begin
            r_tried  <= 1'b1;
            r_second <= r_tried;
        end
    end

    assign w_eval_next = (r_mask == '0) ? RXDET_HOLD :
                         (r_second || r_mask == '1) ? RXDET_REPORT : RXDET_RETRY;
`else
    assign w_eval_next = (r_mask == '0) ? RXDET_HOLD : RXDET_REPORT;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            RXDET_IDLE:   w_next = detect_active_i ? RXDET_REQ : RXDET_IDLE;
            RXDET_REQ:    w_next = RXDET_WAIT;
            RXDET_WAIT:   w_next = (phy_rxdet_done_i || w_to_tc) ? RXDET_EVAL : RXDET_WAIT;
            RXDET_EVAL:   w_next = w_eval_next;
`ifdef RX_DETECT_RETRY_EN
            RXDET_RETRY:  w_next = w_rt_tc ? RXDET_REQ : RXDET_RETRY;
`endif
            RXDET_REPORT: w_next = RXDET_HOLD;
            RXDET_HOLD:   w_next = detect_active_i ? RXDET_HOLD : RXDET_IDLE;
            default:      w_next = RXDET_IDLE;
        endcase
        if (w_abort)
            w_next = RXDET_IDLE;
    end

    // Done takes precedence over the timeout in the same WAIT cycle; abort
    // takes precedence over both.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RXDET_IDLE;
            r_mask  <= '0;
        end else begin
            r_state <= w_next;
            if (w_abort || (r_state == RXDET_HOLD && !detect_active_i))
                r_mask <= '0;
            else if (r_state == RXDET_WAIT && phy_rxdet_done_i)
                r_mask <= phy_rxdet_present_i;
            else if (r_state == RXDET_WAIT && w_to_tc)
                r_mask <= '0;
        end
    end

    assign phy_rxdet_req_o  = r_state == RXDET_REQ;
    assign lane_detect_o    = r_state == RXDET_REPORT;
    assign busy_o           = r_state != RXDET_IDLE && r_state != RXDET_HOLD;
    assign lanes_detected_o = r_mask;

endmodule

// File: doc/rx_detect_seq.md
# rx_detect_seq

Receiver-detection sequencer for the LTSSM Detect substate logic. It sits directly downstream of the Detect quiet/active controller: it starts when that controller reports Detect.Active, drives the PHY receiver-detect request, and collects the per-lane presence results. It returns a single "lane detected" pulse that feeds the controller's lane-detect input, and publishes the detected-lane mask for Polling/Configuration.

## Interface
Parameters:
- NUM_LANES, 4, number of lanes probed (1..32)
- TIMEOUT_CYCLES, 32, max cycles to wait for PHY done before declaring no receivers (>=2)
- RETRY_WAIT_CYCLES, 64, wait between first and second attempt (scaled stand-in for 12 ms, >=1)

Ports:
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  reset, synchronous, active-high
- detect_active_i  input  1  Detect.Active indication from the Detect controller
- phy_rxdet_req_o  output  1  one-cycle request to the PHY to run receiver detection on all lanes
- phy_rxdet_done_i  input  1  PHY reports detection complete; presence vector valid in this cycle
- phy_rxdet_present_i  input  NUM_LANES  per-lane receiver present, sampled only when done is high
- lane_detect_o  output  1  one-cycle pulse: at least one receiver confirmed
- lanes_detected_o  output  NUM_LANES  final detected-lane mask
- busy_o  output  1  sequence in progress

## Operation
- States: IDLE, REQ, WAIT, EVAL, RETRY, REPORT, HOLD.
- IDLE: detect_active_i high -> REQ; mask cleared on entry from HOLD.
- REQ: phy_rxdet_req_o=1 for exactly this cycle. Set attempt flag (first/second). -> WAIT.
- WAIT: counter increments each cycle. done high -> capture present into mask, -> EVAL. Counter reaches TIMEOUT_CYCLES-1 without done -> mask=0, -> EVAL. Done and timeout in the same cycle: done wins.
- EVAL, first attempt: mask all-ones -> REPORT. Mask zero -> HOLD, no pulse. Partial mask -> RETRY.
- EVAL, second attempt: mask nonzero -> REPORT, else HOLD. The second-attempt mask is final.
- RETRY: count RETRY_WAIT_CYCLES, -> REQ.
- REPORT: lane_detect_o=1 for one cycle, -> HOLD.
- HOLD: outputs held; detect_active_i low -> IDLE.
- detect_active_i low in any state other than IDLE/HOLD aborts to IDLE next cycle. Counters and attempt flag clear, mask clears, no pulse. Abort has priority over done/timeout.
- done seen outside WAIT is ignored.
- busy_o=1 in REQ, WAIT, EVAL, RETRY, REPORT.

## Timing
- Reset: state IDLE; phy_rxdet_req_o, lane_detect_o, busy_o = 0; lanes_detected_o = 0; counters = 0.
- detect_active_i sampled high in IDLE at cycle 0 -> req_o high at cycle 1 only.
- done high in WAIT at cycle N -> lanes_detected_o valid from N+1 (EVAL) -> lane_detect_o high at N+2 (all-present case).
- Timeout: req at cycle 1, no done -> EVAL at cycle 2+TIMEOUT_CYCLES.
- Partial first result: second req asserted RETRY_WAIT_CYCLES+1 cycles after EVAL.
- All outputs are decoded from registered state/mask; no combinational input-to-output path.
- Counters are $clog2(max param)+1 bits wide and saturate; no wrap.

## Configuration
- RX_DETECT_RETRY_EN defined: partial first-attempt result goes through RETRY and a second attempt, as above.
- Not defined: RETRY state and retry counter are absent. Any nonzero first-attempt mask -> REPORT. Zero -> HOLD. RETRY_WAIT_CYCLES is unused.

## Structure
- ltssm_pkg gains the rxdet_sm_e state enum and the default localparams for timeout and retry-wait.
- One sub-module, rxdet_counter: a synchronous clear/enable up-counter with terminal-count flag. It is instantiated once for the WAIT timeout and, when RX_DETECT_RETRY_EN is defined, once for the retry wait.

## Test plan
- NUM_LANES=4: raise active; done at 3 cycles after req with present=4'b1111 -> single req pulse; lanes_detected_o=4'b1111; one lane_detect_o pulse 2 cycles after done.
- Present=4'b0000 -> no lane_detect_o; HOLD, busy_o=0; drop active -> IDLE; re-raise -> new req.
- With RX_DETECT_RETRY_EN: first present=4'b0011, second present=4'b0001 -> second req RETRY_WAIT_CYCLES+1 cycles after EVAL; final mask 4'b0001; one pulse. Without the macro: no second req; mask 4'b0011.
- Never assert done -> EVAL at cycle 2+TIMEOUT_CYCLES; mask 0; no pulse. Variant: done on the exact timeout cycle with 4'b1111 -> detection reported.
- Drop detect_active_i during WAIT, then assert done next cycle -> IDLE; done ignored; mask 0; no pulse.
- Assert rst_i mid-RETRY -> all outputs 0 the following cycle; state IDLE.
